// File: rtl/counter_seq_ctrl.sv
// Command sequencer for a WIDTH-bit up/down counter datapath: loads the start value,
// steps toward the stop value, and reports terminal count, completion and abort.
module counter_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_stop,
  input  logic             hold,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_en,
  output logic             cnt_up,
  output logic             busy,
  output logic             tc_pulse,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    HOLD,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       mode_r;
  logic [WIDTH-1:0] start_r;
  logic [WIDTH-1:0] stop_r;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      mode_r  <= '0;
      start_r <= '0;
      stop_r  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) begin
        mode_r  <= cmd_mode;
        start_r <= cmd_start;
        stop_r  <= cmd_stop;
      end
    end
  end

  // mode_r[1] selects wrap behaviour, mode_r[0] selects down counting
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    cnt_up    = (state != IDLE) && !mode_r[0];
    busy      = (state != IDLE);
    tc_pulse  = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = LOAD;
      end
      LOAD: begin
        if (abort) begin
          aborted   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_load  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          aborted   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt_q == stop_r) begin
          tc_pulse = 1'b1;
          if (mode_r[1]) cnt_load = 1'b1;
          else           state_nxt = DONE;
        end else if (hold) begin
          state_nxt = HOLD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          aborted   = 1'b1;
          state_nxt = IDLE;
        end else if (!hold) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (abort) aborted = 1'b1;
        else       done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cnt_load_val = cnt_load ? start_r : '0;

endmodule
